// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes and vector.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IE_BIT   = 0;
    localparam int unsigned SR_EXL_BIT  = 1;
    localparam int unsigned SR_IM_LSB   = 10;
    localparam int unsigned SR_IM_MSB   = 15;

    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_EXC_MSB = 6;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_IP_MSB  = 15;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] EPC_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, interrupt/exception request and eret support.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h4255_4141
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] M_PC,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_isdb,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] rdata,
    output logic [31:0] EPC_out,
    output logic        IntReq
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = sr_ie_q & ~sr_exl_q & (|(HWInt & sr_im_q));
    assign exc_req = (M_ExcCode != 5'd0) & ~sr_exl_q;
    assign IntReq  = int_req | exc_req;

    // A delay-slot instruction restarts at its branch so the branch is re-executed.
    assign exc_pc  = M_isdb ? (M_PC - 32'd4) : M_PC;

    assign sr_word    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    assign cause_word = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
    assign EPC_out    = epc_q;

    always_comb begin
        unique case (addr)
            CP0_SR:    rdata = sr_word;
            CP0_CAUSE: rdata = cause_word;
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID;
            default:   rdata = 32'b0;
        endcase
    end

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (IntReq) begin
            // Interrupt beats a simultaneous exception; any mtc0/eret this cycle is dropped.
            cause_exc_d = int_req ? EXC_INT : M_ExcCode;
            cause_bd_d  = M_isdb;
            epc_d       = exc_pc & EPC_MASK;
            sr_exl_d    = 1'b1;
        end else begin
            if (en && (addr == CP0_SR)) begin
                sr_im_d  = wdata[SR_IM_MSB:SR_IM_LSB];
                sr_exl_d = wdata[SR_EXL_BIT];
                sr_ie_d  = wdata[SR_IE_BIT];
            end
            if (en && (addr == CP0_EPC)) begin
                epc_d = wdata & EPC_MASK;
            end
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'b0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'b0;
            cause_exc_q <= 5'b0;
            epc_q       <= 32'b0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: word-level reference model checked every cycle plus literal checks.
module tb_cp0_unit;

    localparam logic [31:0] PRID_VAL = 32'h4255_4141;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] M_PC;
    logic [4:0]  M_ExcCode;
    logic        M_isdb;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] rdata;
    logic [31:0] EPC_out;
    logic        IntReq;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_sr, m_cause, m_epc;
    logic        model_valid = 1'b0;

    cp0_unit #(.PRID(PRID_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .addr      (addr),
        .wdata     (wdata),
        .M_PC      (M_PC),
        .M_ExcCode (M_ExcCode),
        .M_isdb    (M_isdb),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .rdata     (rdata),
        .EPC_out   (EPC_out),
        .IntReq    (IntReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic m_int();
        return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_req();
        return m_int() || ((M_ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: whole-register words updated by the architectural rules.
    always @(posedge clk) begin
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (m_req()) begin
                m_cause = ({31'd0, M_isdb} << 31) | ({26'd0, HWInt} << 10)
                        | ((m_int() ? 32'd0 : {27'd0, M_ExcCode}) << 2);
                m_epc   = (M_isdb ? M_PC - 32'd4 : M_PC) & ~32'd3;
                m_sr    = m_sr | 32'd2;
            end else begin
                m_cause = (m_cause & ~(32'h3F << 10)) | ({26'd0, HWInt} << 10);
                if (en && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
                if (en && addr == 5'd14) m_epc = wdata & ~32'd3;
                if (EXLClr) m_sr = m_sr & ~32'd2;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("intreq_model", {31'd0, IntReq}, {31'd0, m_req()});
            check("epc_out_model", EPC_out, m_epc);
            check("rdata_model", rdata, m_read(addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; addr = 0; wdata = 0; M_PC = 0; M_ExcCode = 0;
        M_isdb = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;

        // Reset state
        HWInt = 6'h3F;
        rd("reset_sr", 5'd12, 32'h0);
        rd("reset_cause", 5'd13, 32'h0);
        rd("reset_epc", 5'd14, 32'h0);
        rd("reset_prid", 5'd15, 32'h4255_4141);
        check("reset_intreq", {31'd0, IntReq}, 32'd0);
        step();

        // Enabled interrupt
        idle(); en = 1; addr = 5'd12; wdata = 32'h0000_0401;
        step();
        idle(); HWInt = 6'h01; M_PC = 32'h0000_3010;
        #1 check("int_intreq", {31'd0, IntReq}, 32'd1);
        step();
        idle();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_epc", 5'd14, 32'h0000_3010);

        // Overflow in delay slot, SR cleared
        en = 1; addr = 5'd12; wdata = 32'h0;
        step();
        idle(); M_ExcCode = 5'd12; M_isdb = 1; M_PC = 32'h0000_3024;
        #1 check("ov_intreq", {31'd0, IntReq}, 32'd1);
        step();
        idle();
        rd("ov_cause", 5'd13, 32'h8000_0030);
        rd("ov_epc", 5'd14, 32'h0000_3020);

        // EXL masks both exceptions and interrupts
        en = 1; addr = 5'd12; wdata = 32'h0000_0403;
        step();
        idle(); M_ExcCode = 5'd10; HWInt = 6'h01;
        #1 check("exl_mask_intreq", {31'd0, IntReq}, 32'd0);
        step();
        rd("exl_mask_epc", 5'd14, 32'h0000_3020);
        rd("exl_mask_cause", 5'd13, 32'h8000_0430);
        M_ExcCode = 0; EXLClr = 1;
        #1 check("eret_intreq", {31'd0, IntReq}, 32'd0);
        step();
        EXLClr = 0; M_PC = 32'h0000_3040;
        #1 check("post_eret_intreq", {31'd0, IntReq}, 32'd1);
        rd("post_eret_sr", 5'd12, 32'h0000_0401);
        step();

        // eret together with mtc0 SR: EXL forced clear
        idle(); EXLClr = 1; en = 1; addr = 5'd12; wdata = 32'h0000_0003;
        step();
        idle();
        rd("eret_mtc0_sr", 5'd12, 32'h0000_0001);

        // mtc0 EPC dropped under exception
        en = 1; addr = 5'd14; wdata = 32'h0000_5000; M_ExcCode = 5'd4; M_PC = 32'h0000_3100;
        #1 check("drop_intreq", {31'd0, IntReq}, 32'd1);
        step();
        idle();
        rd("drop_epc", 5'd14, 32'h0000_3100);
        check("drop_epc_out", EPC_out, 32'h0000_3100);
        rd("drop_cause", 5'd13, 32'h0000_0010);

        // Interrupt beats simultaneous syscall
        EXLClr = 1; en = 1; addr = 5'd12; wdata = 32'h0000_0401;
        step();
        idle(); HWInt = 6'h01; M_ExcCode = 5'd8; M_PC = 32'h0000_3200;
        step();
        idle();
        rd("prio_cause", 5'd13, 32'h0000_0400);
        rd("prio_epc", 5'd14, 32'h0000_3200);
        en = 1; addr = 5'd14; wdata = 32'h0000_3007;
        step();
        idle();
        rd("epc_align", 5'd14, 32'h0000_3004);

        // Bubble with ExcCode 0 and no interrupt
        EXLClr = 1;
        step();
        idle(); M_PC = 32'h0000_4180;
        #1 check("bubble_intreq", {31'd0, IntReq}, 32'd0);

        // Reset wins over a pending interrupt
        HWInt = 6'h01;
        #1 check("pre_reset_intreq", {31'd0, IntReq}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; HWInt = 0;
        rd("rst_exc_sr", 5'd12, 32'h0);
        rd("rst_exc_cause", 5'd13, 32'h0);
        rd("rst_exc_epc", 5'd14, 32'h0);
        rd("unmapped_addr", 5'd3, 32'h0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 five-stage MIPS core; sits at the M stage.
- Consumes the exception code, PC and delay-slot flag that the pipeline registers carry downstream. Also consumes the external hardware interrupt lines.
- Produces IntReq, which flushes the pipeline registers and redirects fetch to 0x0000_4180. Produces EPC for eret.
- Holds SR, Cause, EPC and PRId; serves mfc0/mtc0.

Parameters:
- PRID, 32'h4255_4141, value returned for PRId reads.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en  in  1  mtc0 write enable (M stage)
- addr  in  5  CP0 register number for read/write
- wdata  in  32  mtc0 write data (forwarded rt)
- M_PC  in  32  PC of the M-stage instruction
- M_ExcCode  in  5  accumulated exception code of the M-stage instruction; 0 = none
- M_isdb  in  1  M-stage instruction is in a branch delay slot
- HWInt  in  6  external interrupt lines, level-sensitive
- EXLClr  in  1  eret in M stage
- rdata  out  32  mfc0 read data, combinational
- EPC_out  out  32  current EPC register value
- IntReq  out  1  take exception/interrupt this cycle, combinational

Behaviour:
- Registers and fields:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC(14): 32 bits, bits[1:0] always 0.
  - PRId(15): constant PRID.
- Reset: SR, Cause and EPC become 0. Outputs then read 0, except PRId, which returns PRID.
- IntReq (combinational):
  - int_req = IE & ~EXL & |(HWInt & IM).
  - exc_req = (M_ExcCode != 0) & ~EXL.
  - IntReq = int_req | exc_req.
- Priority: an interrupt beats an exception in the same cycle.
- On posedge with IntReq=1:
  - Cause.ExcCode <= int_req ? 0 : M_ExcCode.
  - Cause.BD <= M_isdb.
  - EPC <= M_isdb ? {M_PC-4}[31:2],00 : M_PC[31:2],00.
  - SR.EXL <= 1.
- Cause.IP <= HWInt every cycle, including cycles with IntReq. Reset has priority.
- mtc0 (en=1, IntReq=0):
  - addr 12: SR <= IM/EXL/IE fields of wdata.
  - addr 14: EPC <= {wdata[31:2],00}.
  - Other addresses, including 13 and 15: no effect.
- mtc0 with IntReq=1 in the same cycle: the write is dropped; the exception update wins.
- EXLClr=1 and IntReq=0: SR.EXL <= 0 at posedge.
- EXLClr=1 with IntReq=1: exception update wins; EXL stays 1.
- EXLClr with mtc0 to SR in the same cycle: mtc0 is applied first, then EXL is forced to 0.
- Read path: rdata is combinational on addr.
  - 12 → SR, 13 → Cause, 14 → EPC, 15 → PRID, else 0.
  - Pre-edge values are returned; there is no write-through in the same cycle.
- Nested events: while EXL=1, IntReq stays 0 regardless of HWInt or M_ExcCode. A nonzero M_ExcCode under EXL=1 is ignored.
- An M-stage bubble (instr=0, PC=0x4180 after a flush) carries ExcCode 0. It must not raise IntReq unless an interrupt is pending.
- Latency:
  - IntReq: 0 cycles from M-stage inputs.
  - Register updates: visible on rdata/EPC_out 1 cycle later.
- Reset during an exception cycle: reset wins; all registers are 0 after the edge.

Decomposition:
- Shared package cp0_pkg:
  - Register numbers CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Field bit positions.
  - EXC_ENTRY=32'h0000_4180.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
- No sub-module: one flat module with a single sequential block plus combinational request/read logic.

Test Plan:
- Reset, then read addr 12/13/14/15 → 0, 0, 0, 32'h4255_4141; IntReq=0 with HWInt=6'h3F.
- mtc0 SR=32'h0000_0401, then HWInt=6'h01 → IntReq=1 that cycle. Next cycle: Cause=32'h0000_0400, SR.EXL=1, EPC=M_PC (e.g. 32'h0000_3010).
- M_ExcCode=12 (OV), M_isdb=1, M_PC=32'h0000_3024, SR=0 → IntReq=1. Next cycle: Cause=32'h8000_0030, EPC=32'h0000_3020.
- EXL=1 with M_ExcCode=10 and HWInt enabled → IntReq=0 and registers unchanged. Then EXLClr=1 → next cycle EXL=0 and the pending interrupt raises IntReq.
- Same cycle: en=1, addr=14, wdata=32'h0000_5000, with M_ExcCode=4 at M_PC=32'h0000_3100 → EPC=32'h0000_3100 and the write is dropped.
- Same cycle: HWInt enabled and M_ExcCode=8 → Cause.ExcCode=0 (interrupt wins). Also: mtc0 EPC with wdata=32'h0000_3007 → EPC reads 32'h0000_3004.
